// File: rtl/du_mem_dump_ctrl.sv
// -----------------------------------------------------------------------------
// du_mem_dump_ctrl
//
// Purpose:
//   Dumps data-memory words 0..N_WORDS-1 through a 32-bit UART sender. For each
//   word the controller issues a one-cycle read, captures the returned data one
//   cycle later, pulses the sender start and waits for its completion pulse.
//   A run ends with a one-cycle o_done pulse. i_abort ends a run early with no
//   o_done pulse.
//
// Optional feature (macro DU_DUMP_CHECKSUM_EN):
//   Every dumped word is XOR-accumulated. After the last word has been sent,
//   the checksum is sent as one extra word before o_done.
//
// Parameters:
//   NB_DATA  data word width
//   NB_ADDR  data-memory word-address width
//   N_WORDS  words dumped per run (1..2**NB_ADDR)
//
// Ports:
//   i_clock         sole clock, rising edge
//   i_reset         asynchronous reset, active low
//   i_start         one-cycle request to begin a run (honoured in IDLE only)
//   i_abort         terminates a run in progress; wins over i_start/i_tx_32b_done
//   i_mem_data      memory read data, valid one cycle after o_mem_rd_en
//   i_tx_32b_done   sender completion pulse (honoured in WAIT_TX only)
//   o_mem_addr      memory word address (address counter)
//   o_mem_rd_en     memory read strobe, high in READ only
//   o_tx_data       word presented to the sender, stable until its done pulse
//   o_tx_start_32b  one-cycle sender start pulse
//   o_busy          high while the controller is outside IDLE
//   o_done          one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module du_mem_dump_ctrl #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 5,
    parameter int unsigned N_WORDS = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [NB_DATA-1:0] i_mem_data,
    input  logic               i_tx_32b_done,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic               o_mem_rd_en,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start_32b,
    output logic               o_busy,
    output logic               o_done
);

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT_DATA,
        S_SEND,
        S_WAIT_TX,
`ifdef DU_DUMP_CHECKSUM_EN
        S_CHECKSUM,
`endif
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] addr_q, addr_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               rd_en_q, rd_en_d;
    logic               tx_start_q, tx_start_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef DU_DUMP_CHECKSUM_EN
    logic [NB_DATA-1:0] chk_q, chk_d;
    // Set once the checksum word has been launched, so the following WAIT_TX
    // completion leads to DONE instead of another address step.
    logic               chk_sent_q, chk_sent_d;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tx_data_d = tx_data_q;
`ifdef DU_DUMP_CHECKSUM_EN
        chk_d      = chk_q;
        chk_sent_d = chk_sent_q;
`endif

        if (i_abort) begin
            // Abort from any state (including IDLE with a concurrent start).
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_d = S_READ;
                        addr_d  = '0;
`ifdef DU_DUMP_CHECKSUM_EN
                        chk_d      = '0;
                        chk_sent_d = 1'b0;
`endif
                    end
                end
                S_READ: begin
                    state_d = S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    tx_data_d = i_mem_data;
`ifdef DU_DUMP_CHECKSUM_EN
                    chk_d = chk_q ^ i_mem_data;
`endif
                    state_d = S_SEND;
                end
                S_SEND: begin
                    state_d = S_WAIT_TX;
                end
                S_WAIT_TX: begin
                    if (i_tx_32b_done) begin
`ifdef DU_DUMP_CHECKSUM_EN
                        if (chk_sent_q) begin
                            state_d = S_DONE;
                        end else if (addr_q < LAST_ADDR) begin
                            addr_d  = addr_q + NB_ADDR'(1);
                            state_d = S_READ;
                        end else begin
                            // Load the checksum now so it is valid during the
                            // CHECKSUM start pulse.
                            tx_data_d  = chk_q;
                            chk_sent_d = 1'b1;
                            state_d    = S_CHECKSUM;
                        end
`else
                        if (addr_q < LAST_ADDR) begin
                            addr_d  = addr_q + NB_ADDR'(1);
                            state_d = S_READ;
                        end else begin
                            state_d = S_DONE;
                        end
`endif
                    end
                end
`ifdef DU_DUMP_CHECKSUM_EN
                S_CHECKSUM: begin
                    state_d = S_WAIT_TX;
                end
`endif
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        // Outputs are registered from the next state so they line up with it.
        rd_en_d = (state_d == S_READ);
`ifdef DU_DUMP_CHECKSUM_EN
        tx_start_d = (state_d == S_SEND) || (state_d == S_CHECKSUM);
`else
        tx_start_d = (state_d == S_SEND);
`endif
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            tx_data_q  <= '0;
            rd_en_q    <= 1'b0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef DU_DUMP_CHECKSUM_EN
            chk_q      <= '0;
            chk_sent_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            rd_en_q    <= rd_en_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef DU_DUMP_CHECKSUM_EN
            chk_q      <= chk_d;
            chk_sent_q <= chk_sent_d;
`endif
        end
    end

    assign o_mem_addr     = addr_q;
    assign o_mem_rd_en    = rd_en_q;
    assign o_tx_data      = tx_data_q;
    assign o_tx_start_32b = tx_start_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;

endmodule
